// File: rtl/grid_mem_scheduler.sv
// Arbiter for the single-port grid memory: VGA reads first, then the clear sweep, then queued SPI updates.
// Latency: read request to rd_valid 3 cycles; an uncontended update reaches mem_we 2 cycles after wr_valid.
// Backpressure: none upstream; a full FIFO (or, with GRID_BOUNDS_CHECK_EN, an out-of-range word) is dropped with a wr_drop pulse.
module grid_mem_scheduler #(
  parameter int                 GRID_X_BITS = 6,
  parameter int                 GRID_Y_BITS = 5,
  parameter int                 COLOR_W     = 8,
  parameter int                 FIFO_DEPTH  = 4,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 8'h00
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  input  logic [23:0]                        wr_data,
  output logic                               wr_drop,
  input  logic                               clear_req,
  output logic                               clear_busy,
  input  logic                               rd_req,
  input  logic [GRID_X_BITS-1:0]             rd_x,
  input  logic [GRID_Y_BITS-1:0]             rd_y,
  output logic                               rd_valid,
  output logic [COLOR_W-1:0]                 rd_color,
  output logic [GRID_X_BITS+GRID_Y_BITS-1:0] mem_addr,
  output logic                               mem_we,
  output logic [COLOR_W-1:0]                 mem_wdata,
  input  logic [COLOR_W-1:0]                 mem_rdata
);

  localparam int ADDR_W = GRID_X_BITS + GRID_Y_BITS;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic [GRID_X_BITS-1:0] x;
    logic [GRID_Y_BITS-1:0] y;
    logic [COLOR_W-1:0]     color;
  } upd_t;

  logic [0:0]        state_q,     state_d;
  logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  upd_t              fifo_q [FIFO_DEPTH];
  upd_t              fifo_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        rd_pipe_q,   rd_pipe_d;
  logic              rd_valid_q,  rd_valid_d;
  logic [COLOR_W-1:0] rd_color_q,  rd_color_d;
  logic              wr_drop_q,   wr_drop_d;

  logic [7:0] wr_x_full;
  logic [7:0] wr_y_full;
  upd_t       wr_upd;
  upd_t       head;
  logic       wr_in_range;
  logic       fifo_nonempty;
  logic       push;
  logic       grant_clr;
  logic       grant_pop;
  logic       unused_wr_bits;

  assign wr_x_full = wr_data[23:16];
  assign wr_y_full = wr_data[15:8];
  assign wr_upd    = {wr_x_full[GRID_X_BITS-1:0], wr_y_full[GRID_Y_BITS-1:0], wr_data[COLOR_W-1:0]};
  // Upper coordinate bits only matter when bounds checking is built in.
  assign unused_wr_bits = ^{wr_x_full, wr_y_full};

`ifdef GRID_BOUNDS_CHECK_EN
  assign wr_in_range = ((wr_x_full >> GRID_X_BITS) == 8'd0) && ((wr_y_full >> GRID_Y_BITS) == 8'd0);
`else
  assign wr_in_range = 1'b1;
`endif

  assign head          = fifo_q[rd_ptr_q];
  assign fifo_nonempty = (cnt_q != '0);
  // Fullness is judged on the pre-pop count, so a full FIFO drops even while it drains.
  assign push          = wr_valid && wr_in_range && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign grant_clr     = !rd_req && (state_q == ST_CLEAR);
  assign grant_pop     = !rd_req && (state_q == ST_IDLE) && fifo_nonempty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    fifo_d      = fifo_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_pipe_d   = {rd_pipe_q[0], rd_req};
    rd_valid_d  = rd_pipe_q[1];
    rd_color_d  = rd_pipe_q[1] ? mem_rdata : rd_color_q;
    wr_drop_d   = wr_valid && !push;

    if (rd_req) begin
      mem_addr_d = {rd_x, rd_y};
    end else if (grant_clr) begin
      mem_addr_d  = clr_cnt_q;
      mem_we_d    = 1'b1;
      mem_wdata_d = CLEAR_COLOR;
      clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == '1) begin
        state_d = ST_IDLE;
      end
    end else if (grant_pop) begin
      mem_addr_d  = {head.x, head.y};
      mem_we_d    = 1'b1;
      mem_wdata_d = head.color;
      rd_ptr_d    = ptr_inc(rd_ptr_q);
    end

    if ((state_q == ST_IDLE) && clear_req) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = wr_upd;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    case ({push, grant_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_color_q  <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_color_q  <= rd_color_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // Entry contents are don't-care while the count says empty, so storage skips reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_color   = rd_color_q;
  assign wr_drop    = wr_drop_q;
  assign clear_busy = (state_q == ST_CLEAR);

endmodule
